sw_io_port: RTL and testbench

//  CPU-side responder for the switch/LED operator interface of picoMIPS.
//  - Synchronises SW[7:0] (data) and SW[8] (go); optionally debounces go.
//  - Captures the data byte on each debounced go assertion and holds it valid until the CPU acks.
//  - Re-arms only after go is released. Also owns the LED output register written by the CPU.

---
 rtl/sw_io_pkg.sv | 14 +
 rtl/sw_sync_debounce.sv | 62 ++++++
 rtl/sw_io_port.sv | 97 +++++++++
 tb/tb_sw_io_port.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sw_io_pkg.sv
// Shared types and defaults for the picoMIPS switch/LED operator port.
// The optional go debouncer is enabled by the SW_IO_DEBOUNCE_EN macro.
package sw_io_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        PENDING,
        RELEASE
    } state_t;

endpackage

// File: rtl/sw_sync_debounce.sv
// One-bit synchroniser with an optional debouncer on its output.
// Define SW_IO_DEBOUNCE_EN to enable the DEBOUNCE_CYCLES stability filter.
module sw_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic db_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef SW_IO_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    // The counter only runs while the synchronised input disagrees with the filtered value.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_s != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db_o = db_q;
`else
    // Without the filter, the last synchroniser flop is the go_db register itself.
    assign db_o = sync_s;
`endif

endmodule

// File: rtl/sw_io_port.sv
// CPU-side responder for the picoMIPS switch/LED operator interface.
// Build option: define SW_IO_DEBOUNCE_EN to debounce the go switch.
module sw_io_port
    import sw_io_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              sw_go,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_out,
    input  logic              cpu_ack,
    input  logic              led_we,
    input  logic [DATA_W-1:0] led_wdata,
    output logic [DATA_W-1:0] led
);

    logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync_q;
    logic [DATA_W-1:0]                  data_s;
    logic                               go_db;

    state_t            state_q, state_d;
    logic              data_valid_q, data_valid_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [DATA_W-1:0] led_q, led_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_sync_q <= '0;
        end else begin
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], sw_data};
        end
    end

    assign data_s = data_sync_q[SYNC_STAGES-1];

    sw_sync_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_go_sync (
        .clk  (clk),
        .reset(reset),
        .raw_i(sw_go),
        .db_o (go_db)
    );

    // RELEASE waits for go to drop so one long press yields exactly one byte.
    always_comb begin
        state_d      = state_q;
        data_valid_d = data_valid_q;
        data_out_d   = data_out_q;
        led_d        = led_we ? led_wdata : led_q;
        case (state_q)
            IDLE: begin
                if (go_db) state_d = CAPTURE;
            end
            CAPTURE: begin
                data_out_d   = data_s;
                data_valid_d = 1'b1;
                state_d      = PENDING;
            end
            PENDING: begin
                if (cpu_ack) begin
                    data_valid_d = 1'b0;
                    state_d      = RELEASE;
                end
            end
            RELEASE: begin
                if (!go_db) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
            led_q        <= '0;
        end else begin
            state_q      <= state_d;
            data_valid_q <= data_valid_d;
            data_out_q   <= data_out_d;
            led_q        <= led_d;
        end
    end

    assign data_valid = data_valid_q;
    assign data_out   = data_out_q;
    assign led        = led_q;

endmodule

// File: tb/tb_sw_io_port.sv
// Testbench for sw_io_port: directed vector table, corner sequences and randomized transactions.
// Expected latency follows the SW_IO_DEBOUNCE_EN setting of the build.
module tb_sw_io_port;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
`ifdef SW_IO_DEBOUNCE_EN
    localparam int LAT = SYNC_STAGES + DEBOUNCE_CYCLES + 2;
`else
    localparam int LAT = SYNC_STAGES + 2;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw_data;
    logic       sw_go;
    logic       data_valid;
    logic [7:0] data_out;
    logic       cpu_ack;
    logic       led_we;
    logic [7:0] led_wdata;
    logic [7:0] led;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] modelLed;

    typedef struct {
        string      name;
        logic       rst;
        logic       go;
        logic [7:0] data;
        logic       ack;
        logic       we;
        logic [7:0] wdata;
        int         cycles;
        logic       expValid;
        logic [7:0] expData;
        logic [7:0] expLed;
    } vec_t;

    vec_t vecs[$];

    sw_io_port #(
        .DATA_W         (8),
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_data   (sw_data),
        .sw_go     (sw_go),
        .data_valid(data_valid),
        .data_out  (data_out),
        .cpu_ack   (cpu_ack),
        .led_we    (led_we),
        .led_wdata (led_wdata),
        .led       (led)
    );

    always #5 clk = ~clk;

    // Abort a hung run with a visible failure rather than spinning forever.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(string name, logic rst, logic go, logic [7:0] data, logic ack,
                                logic we, logic [7:0] wdata, int cycles,
                                logic expValid, logic [7:0] expData, logic [7:0] expLed);
        vec_t v;
        v.name = name; v.rst = rst; v.go = go; v.data = data; v.ack = ack;
        v.we = we; v.wdata = wdata; v.cycles = cycles;
        v.expValid = expValid; v.expData = expData; v.expLed = expLed;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        reset     = v.rst;
        sw_go     = v.go;
        sw_data   = v.data;
        cpu_ack   = v.ack;
        led_we    = v.we;
        led_wdata = v.wdata;
        repeat (v.cycles) tick();
    endtask

    // One randomized clock edge with random LED traffic checked against the register model.
    task automatic randTick();
        led_we    = ($urandom_range(0, 3) == 0);
        led_wdata = 8'($urandom);
        tick();
        if (led_we) modelLed = led_wdata;
        checkOutput("rnd_led", {24'd0, led}, {24'd0, modelLed});
    endtask

    initial begin
        logic [7:0] b;
        int         edges;
        int         waitAck;
        int         dropGo;

        reset = 1'b1; sw_go = 1'b0; sw_data = 8'h00; cpu_ack = 1'b0;
        led_we = 1'b0; led_wdata = 8'h00;

        vecs.push_back(mk("reset_hold",    1, 1, 8'hFF, 0, 0, 8'h00, 2,       0, 8'h00, 8'h00));
        vecs.push_back(mk("after_reset",   0, 0, 8'h02, 0, 0, 8'h00, LAT + 2, 0, 8'h00, 8'h00));
        vecs.push_back(mk("lat_minus1",    0, 1, 8'h02, 0, 0, 8'h00, LAT - 1, 0, 8'h00, 8'h00));
        vecs.push_back(mk("lat_exact",     0, 1, 8'h02, 0, 0, 8'h00, 1,       1, 8'h02, 8'h00));
        vecs.push_back(mk("ack_clears",    0, 1, 8'h02, 1, 0, 8'h00, 1,       0, 8'h02, 8'h00));
        vecs.push_back(mk("no_recapture",  0, 1, 8'h02, 0, 0, 8'h00, 10,      0, 8'h02, 8'h00));
        vecs.push_back(mk("ack_in_rel",    0, 1, 8'h02, 1, 1, 8'h3C, 1,       0, 8'h02, 8'h3C));
        vecs.push_back(mk("go_release",    0, 0, 8'h02, 0, 0, 8'h00, LAT + 2, 0, 8'h02, 8'h3C));
`ifdef SW_IO_DEBOUNCE_EN
        vecs.push_back(mk("glitch_high",   0, 1, 8'h99, 0, 0, 8'h00, DEBOUNCE_CYCLES - 1, 0, 8'h02, 8'h3C));
        vecs.push_back(mk("glitch_after",  0, 0, 8'h99, 0, 0, 8'h00, LAT + 4, 0, 8'h02, 8'h3C));
`endif
        vecs.push_back(mk("cap_a5",        0, 1, 8'hA5, 0, 0, 8'h00, LAT,     1, 8'hA5, 8'h3C));
        vecs.push_back(mk("ack_and_led",   0, 1, 8'hA5, 1, 1, 8'h81, 1,       0, 8'hA5, 8'h81));
        vecs.push_back(mk("release2",      0, 0, 8'hA5, 0, 0, 8'h00, LAT + 2, 0, 8'hA5, 8'h81));
        vecs.push_back(mk("ack_in_idle",   0, 0, 8'h5C, 1, 0, 8'h00, 3,       0, 8'hA5, 8'h81));
        vecs.push_back(mk("cap_after_idl", 0, 1, 8'h5C, 0, 0, 8'h00, LAT,     1, 8'h5C, 8'h81));
        vecs.push_back(mk("ack3",          0, 1, 8'h5C, 1, 0, 8'h00, 1,       0, 8'h5C, 8'h81));
        vecs.push_back(mk("release3",      0, 0, 8'h5C, 0, 0, 8'h00, LAT + 2, 0, 8'h5C, 8'h81));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput({vecs[i].name, "_valid"}, {31'd0, data_valid}, {31'd0, vecs[i].expValid});
            checkOutput({vecs[i].name, "_data"}, {24'd0, data_out}, {24'd0, vecs[i].expData});
            checkOutput({vecs[i].name, "_led"}, {24'd0, led}, {24'd0, vecs[i].expLed});
        end
        cpu_ack = 1'b0; led_we = 1'b0;

        // Data changes after capture must not disturb the pending byte; the next press takes the new value.
        sw_data = 8'hA5; sw_go = 1'b1;
        repeat (LAT) tick();
        checkOutput("t4_valid", {31'd0, data_valid}, 32'd1);
        checkOutput("t4_first", {24'd0, data_out}, 32'hA5);
        sw_data = 8'h3C;
        repeat (3) tick();
        checkOutput("t4_hold", {24'd0, data_out}, 32'hA5);
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        sw_go = 1'b0;
        repeat (LAT + 2) tick();
        sw_go = 1'b1;
        repeat (LAT) tick();
        checkOutput("t4_second_v", {31'd0, data_valid}, 32'd1);
        checkOutput("t4_second", {24'd0, data_out}, 32'h3C);
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        sw_go = 1'b0;
        repeat (LAT + 2) tick();

        // Reset while a byte is pending drops it; a go held through reset captures again after full latency.
        led_we = 1'b1; led_wdata = 8'hC3; tick(); led_we = 1'b0;
        sw_data = 8'h77; sw_go = 1'b1;
        repeat (LAT) tick();
        checkOutput("t6_pending", {31'd0, data_valid}, 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        checkOutput("t6_rst_valid", {31'd0, data_valid}, 32'd0);
        checkOutput("t6_rst_data", {24'd0, data_out}, 32'h00);
        checkOutput("t6_rst_led", {24'd0, led}, 32'h00);
        repeat (LAT - 1) tick();
        checkOutput("t6_early", {31'd0, data_valid}, 32'd0);
        tick();
        checkOutput("t6_recap_v", {31'd0, data_valid}, 32'd1);
        checkOutput("t6_recap_d", {24'd0, data_out}, 32'h77);
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        sw_go = 1'b0;
        repeat (LAT + 2) tick();

        // Randomized transactions: one byte per press, fixed latency, ack-driven handshake.
        led_we = 1'b1; led_wdata = 8'h5A; tick(); modelLed = 8'h5A;
        for (int t = 0; t < 24; t++) begin
            b = 8'($urandom);
            sw_data = b;
            sw_go = 1'b0;
            repeat (LAT + 2 + $urandom_range(0, 3)) randTick();
            sw_go = 1'b1;
            edges = 0;
            while (data_valid !== 1'b1 && edges < LAT + 8) begin
                randTick();
                edges++;
            end
            checkOutput("rnd_latency", edges, LAT);
            checkOutput("rnd_byte", {24'd0, data_out}, {24'd0, b});
            sw_data = 8'($urandom);
            dropGo  = $urandom_range(0, 1);
            waitAck = $urandom_range(0, 5);
            if (dropGo != 0) sw_go = 1'b0;
            for (int k = 0; k < waitAck; k++) begin
                randTick();
                checkOutput("rnd_pend_v", {31'd0, data_valid}, 32'd1);
                checkOutput("rnd_pend_d", {24'd0, data_out}, {24'd0, b});
            end
            cpu_ack = 1'b1;
            randTick();
            cpu_ack = 1'b0;
            checkOutput("rnd_acked", {31'd0, data_valid}, 32'd0);
            repeat ($urandom_range(2, 6)) begin
                randTick();
                checkOutput("rnd_no_recap", {31'd0, data_valid}, 32'd0);
            end
        end
        led_we = 1'b0;
        sw_go = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
